fifo_memory: RTL and testbench

FIFO_MEMORY -- requirements
Module: fifo_memory

---
 rtl/fifo_memory_pkg.sv | 7 +
 rtl/fifo_memory_ram.sv | 21 ++
 rtl/fifo_memory.sv | 82 ++++++++
 tb/tb_fifo_memory.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/fifo_memory_pkg.sv
// Shared default geometry and flag thresholds for the synchronous FIFO.
package fifo_memory_pkg;
    localparam int FIFO_DATA_WIDTH = 8;
    localparam int FIFO_ADDR_WIDTH = 4;
    localparam int FIFO_ALE_THRESH = 2;
    localparam int FIFO_ALF_THRESH = 14;
endpackage

// File: rtl/fifo_memory_ram.sv
// DEPTH x DATA_WIDTH storage with one synchronous write port and one registered read port.
module fifo_memory_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);
    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    // Same-address read and write in one cycle returns the old word.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end
endmodule

// File: rtl/fifo_memory.sv
// Single-clock FIFO: pointers, occupancy counter, status flags and error pulses around fifo_memory_ram.
module fifo_memory
    import fifo_memory_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH,
    parameter int ALE_THRESH = FIFO_ALE_THRESH,
    parameter int ALF_THRESH = FIFO_ALF_THRESH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  write,
    input  logic                  read,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  empty,
    output logic                  full,
    output logic                  ale,
    output logic                  alf,
    output logic                  wr_err,
    output logic                  rd_err
);
    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] ALE_C   = (ADDR_WIDTH+1)'(ALE_THRESH);
    localparam logic [ADDR_WIDTH:0] ALF_C   = (ADDR_WIDTH+1)'(ALF_THRESH);

    logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic [ADDR_WIDTH:0]   count;
    logic                  wr_ok, rd_ok;
    logic                  dout_valid;
    logic [DATA_WIDTH-1:0] ram_data;

    assign empty = (count == '0);
    assign full  = (count == DEPTH_C);
    assign ale   = (count <= ALE_C);
    assign alf   = (count >= ALF_C);

    // A read frees a slot in the same cycle, so a full FIFO still takes a paired write.
    assign rd_ok = read && !empty;
    assign wr_ok = write && (!full || rd_ok);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            wr_err     <= 1'b0;
            rd_err     <= 1'b0;
            dout_valid <= 1'b0;
        end else begin
            wr_err <= write && !wr_ok;
            rd_err <= read && !rd_ok;
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) begin
                rd_ptr     <= rd_ptr + 1'b1;
                dout_valid <= 1'b1;
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // The RAM read register has no reset; mask it until a read lands after reset.
    assign dout = dout_valid ? ram_data : '0;

    fifo_memory_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk    (clk),
        .wr_en  (wr_ok),
        .wr_addr(wr_ptr),
        .wr_data(din),
        .rd_en  (rd_ok),
        .rd_addr(rd_ptr),
        .rd_data(ram_data)
    );
endmodule

// File: tb/tb_fifo_memory.sv
// Directed self-checking bench for fifo_memory.
module tb_fifo_memory;
    import fifo_memory_pkg::*;

    localparam int DW = FIFO_DATA_WIDTH;

    logic          clk;
    logic          reset;
    logic [DW-1:0] din;
    logic          write;
    logic          read;
    logic [DW-1:0] dout;
    logic          empty, full, ale, alf, wr_err, rd_err;

    int vectors    = 0;
    int miscompares = 0;

    fifo_memory dut (
        .clk   (clk),
        .reset (reset),
        .din   (din),
        .write (write),
        .read  (read),
        .dout  (dout),
        .empty (empty),
        .full  (full),
        .ale   (ale),
        .alf   (alf),
        .wr_err(wr_err),
        .rd_err(rd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Apply one cycle of stimulus; outputs are stable 1 time unit after the edge.
    task automatic op(input logic w, input logic r, input logic [DW-1:0] d);
        write = w;
        read  = r;
        din   = d;
        @(posedge clk);
        #1;
        write = 1'b0;
        read  = 1'b0;
    endtask

    task automatic chk_flags(input string tag, input logic e, input logic f,
                             input logic ae, input logic af);
        chk({tag, ".empty"}, 32'(empty), 32'(e));
        chk({tag, ".full"},  32'(full),  32'(f));
        chk({tag, ".ale"},   32'(ale),   32'(ae));
        chk({tag, ".alf"},   32'(alf),   32'(af));
    endtask

    initial begin
        reset = 1'b0;
        write = 1'b0;
        read  = 1'b0;
        din   = '0;
        #12;
        chk_flags("rst", 1'b1, 1'b0, 1'b1, 1'b0);
        chk("rst.dout", 32'(dout), 32'h0);
        chk("rst.wr_err", 32'(wr_err), 32'h0);
        chk("rst.rd_err", 32'(rd_err), 32'h0);
        @(posedge clk);
        #1 reset = 1'b1;

        // Fill with 0x00..0x0F
        for (int i = 0; i < 16; i++) begin
            op(1'b1, 1'b0, DW'(i));
            if (i == 1)  chk_flags("fill2", 1'b0, 1'b0, 1'b1, 1'b0);
            if (i == 2)  chk_flags("fill3", 1'b0, 1'b0, 1'b0, 1'b0);
            if (i == 12) chk_flags("fill13", 1'b0, 1'b0, 1'b0, 1'b0);
            if (i == 13) chk_flags("fill14", 1'b0, 1'b0, 1'b0, 1'b1);
        end
        chk_flags("fill16", 1'b0, 1'b1, 1'b0, 1'b1);
        chk("fill16.wr_err", 32'(wr_err), 32'h0);
        chk("fill16.dout", 32'(dout), 32'h0);
        op(1'b1, 1'b0, 8'hFF);
        chk("ovf.wr_err", 32'(wr_err), 32'h1);
        chk("ovf.full", 32'(full), 32'h1);
        op(1'b0, 1'b0, 8'h00);
        chk("ovf.wr_err_clr", 32'(wr_err), 32'h0);

        // Drain in order
        for (int i = 0; i < 16; i++) begin
            op(1'b0, 1'b1, 8'h00);
            chk($sformatf("drain%0d.dout", i), 32'(dout), 32'(i));
            chk($sformatf("drain%0d.rd_err", i), 32'(rd_err), 32'h0);
        end
        chk_flags("drained", 1'b1, 1'b0, 1'b1, 1'b0);
        op(1'b0, 1'b1, 8'h00);
        chk("udf.rd_err", 32'(rd_err), 32'h1);
        chk("udf.dout", 32'(dout), 32'h0F);
        op(1'b0, 1'b0, 8'h00);
        chk("udf.rd_err_clr", 32'(rd_err), 32'h0);
        chk("udf.dout_hold", 32'(dout), 32'h0F);

        // Almost-empty / almost-full thresholds
        op(1'b1, 1'b0, 8'h10);
        op(1'b1, 1'b0, 8'h11);
        op(1'b1, 1'b0, 8'h12);
        chk_flags("occ3", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("occ3.dout_hold", 32'(dout), 32'h0F);
        op(1'b0, 1'b1, 8'h00);
        chk("occ2.dout", 32'(dout), 32'h10);
        chk_flags("occ2", 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 12; i++) begin
            op(1'b1, 1'b0, DW'(8'h20 + i));
            if (i == 10) chk_flags("occ13", 1'b0, 1'b0, 1'b0, 1'b0);
        end
        chk_flags("occ14", 1'b0, 1'b0, 1'b0, 1'b1);
        op(1'b0, 1'b1, 8'h00);
        chk("occ13.dout", 32'(dout), 32'h11);
        chk_flags("occ13b", 1'b0, 1'b0, 1'b0, 1'b0);
        op(1'b0, 1'b1, 8'h00);
        chk("thr.drain0", 32'(dout), 32'h12);
        for (int i = 0; i < 12; i++) begin
            op(1'b0, 1'b1, 8'h00);
            chk($sformatf("thr.drain%0d", i + 1), 32'(dout), 32'(8'h20 + i));
        end
        chk_flags("thr.empty", 1'b1, 1'b0, 1'b1, 1'b0);

        // Full FIFO with simultaneous read and write
        for (int i = 0; i < 16; i++) op(1'b1, 1'b0, DW'(8'h40 + i));
        chk("rw.full0", 32'(full), 32'h1);
        for (int i = 0; i < 16; i++) begin
            op(1'b1, 1'b1, 8'hA5);
            chk($sformatf("rw%0d.dout", i), 32'(dout), 32'(8'h40 + i));
            chk($sformatf("rw%0d.full", i), 32'(full), 32'h1);
            chk($sformatf("rw%0d.errs", i), 32'({wr_err, rd_err}), 32'h0);
        end
        for (int i = 0; i < 16; i++) begin
            op(1'b0, 1'b1, 8'h00);
            chk($sformatf("rwd%0d.dout", i), 32'(dout), 32'hA5);
        end
        chk_flags("rw.empty", 1'b1, 1'b0, 1'b1, 1'b0);

        // Empty FIFO with simultaneous read and write: write only
        op(1'b1, 1'b1, 8'h3C);
        chk("er.rd_err", 32'(rd_err), 32'h1);
        chk("er.wr_err", 32'(wr_err), 32'h0);
        chk("er.empty", 32'(empty), 32'h0);
        chk("er.dout_hold", 32'(dout), 32'hA5);
        op(1'b0, 1'b1, 8'h00);
        chk("er.dout", 32'(dout), 32'h3C);
        chk("er.rd_err_clr", 32'(rd_err), 32'h0);
        chk("er.empty2", 32'(empty), 32'h1);

        // Mid-stream reset at occupancy 9
        for (int i = 0; i < 9; i++) op(1'b1, 1'b0, DW'(8'h50 + i));
        op(1'b0, 1'b1, 8'h00);
        chk("pre.dout", 32'(dout), 32'h50);
        op(1'b1, 1'b0, 8'h59);
        chk_flags("pre", 1'b0, 1'b0, 1'b0, 1'b0);
        #2 reset = 1'b0;
        #1;
        chk_flags("midrst", 1'b1, 1'b0, 1'b1, 1'b0);
        chk("midrst.dout", 32'(dout), 32'h0);
        @(posedge clk);
        #1 reset = 1'b1;
        chk("post.empty", 32'(empty), 32'h1);
        op(1'b1, 1'b0, 8'h77);
        chk("post.dout0", 32'(dout), 32'h0);
        op(1'b0, 1'b1, 8'h00);
        chk("post.dout", 32'(dout), 32'h77);
        chk_flags("post", 1'b1, 1'b0, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
